// File: rtl/joy_db15_tx.sv
// Device side of the DB15 serial joystick link: answers JOY_LOAD/JOY_CLK strobes with two players' buttons.
// Optional strobe glitch filter: define JOY_DB15_TX_DEGLITCH_EN.
module joy_db15_tx #(
    parameter int BITS        = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_sys,
    input  logic            RESET,
    input  logic [BITS-1:0] joy1_i,
    input  logic [BITS-1:0] joy2_i,
    input  logic            JOY_CLK,
    input  logic            JOY_LOAD,
    output logic            JOY_DATA,
    output logic            frame_done,
    output logic            bit_overrun
);

    localparam int FRAME = 2 * BITS;
    localparam int CW    = $clog2(FRAME + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Strobe index 0 is JOY_CLK, index 1 is JOY_LOAD.
    logic [1:0] w_pin;
    logic [1:0] w_level;
    logic [1:0] w_prev;

    assign w_pin = {JOY_LOAD, JOY_CLK};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_strobe
            logic [SYNC_STAGES-1:0] r_sync;
            logic                   r_prev;
            logic                   w_lvl;
`ifdef JOY_DB15_TX_DEGLITCH_EN
            logic                   r_last;

            always_ff @(posedge clk_sys) begin
                if (RESET) begin
                    r_last <= 1'b1;
                end else begin
                    r_last <= r_sync[SYNC_STAGES-1];
                end
            end

            // Level only follows the pin after two equal synced samples; r_prev holds it otherwise.
            assign w_lvl = (r_sync[SYNC_STAGES-1] == r_last) ? r_last : r_prev;
`else
            assign w_lvl = r_sync[SYNC_STAGES-1];
`endif

            always_ff @(posedge clk_sys) begin
                if (RESET) begin
                    r_sync <= '1;
                    r_prev <= 1'b1;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], w_pin[gi]};
                    r_prev <= w_lvl;
                end
            end

            assign w_level[gi] = w_lvl;
            assign w_prev[gi]  = r_prev;
        end
    endgenerate

    logic w_clk_rise;
    logic w_load_fall;
    logic w_load_rise;

    assign w_clk_rise  =  w_level[0] & ~w_prev[0];
    assign w_load_fall = ~w_level[1] &  w_prev[1];
    assign w_load_rise =  w_level[1] & ~w_prev[1];

    state_t          r_state, w_state_next;
    logic [FRAME-1:0] r_sr, w_sr_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic            r_done, w_done_next;
    logic            r_ovr, w_ovr_next;

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_sr    <= '1;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sr    <= w_sr_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
            r_ovr   <= w_ovr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sr_next    = r_sr;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        w_ovr_next   = r_ovr;
        // A load fall outranks any clock edge seen in the same cycle.
        if (w_load_fall) begin
            w_state_next = ST_LOAD;
            w_sr_next    = {~joy1_i, ~joy2_i};
            w_cnt_next   = '0;
            w_ovr_next   = 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_load_rise) begin
                        w_state_next = ST_SHIFT;
                    end else begin
                        w_sr_next = {~joy1_i, ~joy2_i};
                    end
                end
                ST_SHIFT: begin
                    if (w_clk_rise) begin
                        w_sr_next  = {r_sr[FRAME-2:0], 1'b1};
                        w_cnt_next = r_cnt + 1'b1;
                        if (r_cnt == LAST_IDX) begin
                            w_done_next  = 1'b1;
                            w_state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_clk_rise) begin
                        w_ovr_next = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign JOY_DATA    = r_sr[FRAME-1];
    assign frame_done  = r_done;
    assign bit_overrun = r_ovr;

endmodule
